router_fifo: RTL and testbench
==============================

# router_fifo

Per-port output buffer of the 1x3 router: stores bytes produced by the register/parity stage (its `dout`) and presents them to the destination read interface. One instance per output port (three total). Each entry carries a header-marker bit, so the read side knows where each packet starts and how many bytes it has. It also generates `data_out` framing and the `full`/`empty` flags used by the FSM and synchronizer.

## Interface
- DEPTH, 16, number of entries; power of two.
- WIDTH, 8, data byte width; stored word is WIDTH+1 (bit WIDTH = header marker).
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- soft_reset  in  1  synchronous active-high flush from synchronizer timeout; same effect as reset
- write_enb  in  1  write request (from synchronizer, port-decoded)
- read_enb  in  1  read request from destination
- lfd_state  in  1  marks current write as header byte
- data_in  in  8  byte from register stage `dout`
- data_out  out  8  registered read data
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries

## Operation
- Storage: DEPTH x 9 array; write stores {lfd_q, data_in}, where lfd_q = lfd_state delayed one clock. The register stage drives the header one cycle after lfd_state.
- Pointers: wr_ptr, rd_ptr, each log2(DEPTH)+1 bits; low bits index, MSB is wrap bit; increment mod 2*DEPTH.
- empty = (wr_ptr == rd_ptr); full = index bits equal and wrap bits differ. Both are combinational from the registered pointers.
- Write accepted iff write_enb && !full; mem[wr_idx] <= {lfd_q, data_in}; wr_ptr++.
- Read accepted iff read_enb && !empty; data_out <= mem[rd_idx][7:0]; rd_ptr++.
- Packet counter count (7 bits) on an accepted read:
  - Entry bit 8 = 1 (header): count <= mem[rd_idx][7:2] + 1, i.e. payload length plus parity byte.
  - Else if count != 0: count <= count - 1.
- Cycle without an accepted read: if count == 0, data_out <= 0; otherwise data_out holds.
- Simultaneous read and write:
  - Not full and not empty: both occur; occupancy unchanged.
  - Empty: write only; no read-through.
  - Full: read occurs; write is dropped that cycle. The upstream FSM stalls on `full`, so this is the required behaviour.
- Priority: resetn low > soft_reset high > normal operation.
- Reset / soft_reset effect: all entries cleared to 0, wr_ptr = rd_ptr = 0, count = 0, lfd_q = 0, data_out = 0. A packet in flight is discarded. A write or read asserted in the same cycle is ignored.

## Timing
- Reset values: data_out = 0, empty = 1, full = 0.
- Write-to-empty-deassert: 1 cycle; empty falls the cycle after the accepted write edge.
- Read latency: data_out valid 1 cycle after read_enb is sampled high with !empty.
- full asserts the cycle after the DEPTH-th outstanding write. It deasserts the cycle after the first read from full.
- Sustained throughput: one write and one read per clock.
- Wrap-around: after 2*DEPTH writes, pointers return to 0 with flags correct. No entry is skipped or repeated.
- Header length 0 (data[7:2] = 0): count = 1; only the parity byte follows.

## Test plan
- Reset: resetn=0 for 1 cycle -> empty=1, full=0, data_out=0; read_enb=1 while empty -> data_out stays 0, rd_ptr unchanged.
- Single packet: write header 8'h0D (lfd), payloads 8'hA1, 8'hA2, 8'hA3, parity 8'h5C. Then read 5 cycles -> data_out 0D, A1, A2, A3, 5C; count 4, 3, 2, 1, 0; empty=1. Next idle cycle data_out=0.
- Fill/overflow: 16 writes -> full=1. 17th write 8'hFF is dropped. 16 reads return the original 16 bytes in order, then empty=1.
- Full with simultaneous read/write: at full, read_enb=1 and write_enb=1 -> one byte out, write dropped, full=0 next cycle. Streaming read+write for 40 cycles across wrap -> data order preserved.
- soft_reset mid-packet: after header 8'h11 and 2 payloads read, assert soft_reset -> next cycle empty=1, data_out=0, count=0. A new packet then reads correctly from index 0.
- Back-to-back packets: header 8'h05 (len 1) + payload + parity, then header 8'h09 (len 2) + 2 payloads + parity, read continuously. Counter reloads on the second header; data_out is never forced to 0 between packets.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer of the 1x3 router.
// Stores bytes from the register stage together with a header-marker bit.
// Tracks the remaining bytes of the packet being read so data_out returns
// to zero once a packet has drained. Reports full/empty to the FSM and
// to the synchronizer.
module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = WIDTH - 1;        // packet counter width (7 for bytes)
   localparam int LW = WIDTH - 2;        // header length field data[WIDTH-1:2]

   logic [WIDTH:0]  mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   rd_idx;
   logic            lfd_q;
   logic [CW-1:0]   count;
   logic            do_write;
   logic            do_read;
   logic            flush;
   logic [WIDTH:0]  rd_word;
   logic [LW-1:0]   hdr_len;

   assign wr_idx  = wr_ptr[AW-1:0];
   assign rd_idx  = rd_ptr[AW-1:0];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
   assign flush   = !resetn || soft_reset;
   // A full FIFO drops the write even when a read frees a slot that cycle.
   assign do_write = write_enb && !full;
   // An empty FIFO never reads through the word being written.
   assign do_read  = read_enb && !empty;
   assign rd_word  = mem[rd_idx];
   assign hdr_len  = rd_word[WIDTH-1:2];

   // Storage array: cleared on any flush, otherwise takes accepted writes.
   always_ff @(posedge clock) begin
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_write) begin
         mem[wr_idx] <= {lfd_q, data_in};
      end
   end

   // Pointers and header-marker delay; lfd_q lines up with the header byte.
   // The register stage presents that byte one clock after lfd_state.
   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lfd_q  <= 1'b0;
      end else begin
         lfd_q <= lfd_state;
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Read data and packet counter; data_out idles at zero between packets.
   always_ff @(posedge clock) begin
      if (flush) begin
         data_out <= '0;
         count    <= '0;
      end else if (do_read) begin
         data_out <= rd_word[WIDTH-1:0];
         if (rd_word[WIDTH]) begin
            // Header: remaining bytes are the payload plus the parity byte.
            count <= CW'(hdr_len) + 1'b1;
         end else if (count != '0) begin
            count <= count - 1'b1;
         end
      end else if (count == '0) begin
         data_out <= '0;
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: self-checking bench for router_fifo using a queue-based
// reference model of the buffer, packet counter and data_out framing.
module tb_router_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic       clock;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference model state
   logic [8:0] mq[$];
   logic [7:0] mdout;
   logic [6:0] mcnt;
   logic       mlfd;

   router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference behaviour at one rising edge, using the inputs held across it.
   task automatic model_edge();
      logic rd;
      logic wr;
      logic [8:0] e;
      if (!resetn || soft_reset) begin
         mq.delete();
         mcnt  = 7'd0;
         mlfd  = 1'b0;
         mdout = 8'h00;
      end else begin
         rd = read_enb && (mq.size() != 0);
         wr = write_enb && (mq.size() != DEPTH);
         if (rd) begin
            e = mq.pop_front();
            mdout = e[7:0];
            if (e[8]) mcnt = {1'b0, e[7:2]} + 7'd1;
            else if (mcnt != 0) mcnt = mcnt - 7'd1;
         end else if (mcnt == 0) begin
            mdout = 8'h00;
         end
         if (wr) mq.push_back({mlfd, data_in});
         mlfd = lfd_state;
      end
   endtask

   // Drive one cycle of inputs, advance one clock, settle past the edge.
   task automatic step(input logic w, input logic r, input logic l, input logic [7:0] d);
      write_enb = w;
      read_enb  = r;
      lfd_state = l;
      data_in   = d;
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      soft_reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      total_cnt++;
      if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++;
      if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
      total_cnt++;
      if (data_out !== 8'h00) $display("FAIL reset_dout: got %h want 00", data_out); else pass_cnt++;
      resetn = 1'b1;
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total_cnt++;
      if (data_out !== 8'h00 || empty !== 1'b1)
         $display("FAIL read_empty: got dout=%h empty=%b want 00/1", data_out, empty);
      else pass_cnt++;
      total_cnt++;
      if (dut.rd_ptr !== 5'd0) $display("FAIL read_empty_ptr: got %0d want 0", dut.rd_ptr); else pass_cnt++;
   endtask

   task automatic test_single_packet();
      logic [7:0] exp_d [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
      logic [6:0] exp_c [5] = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, exp_d[0]);
      total_cnt++;
      if (empty !== 1'b0) $display("FAIL single_empty_fall: got %b want 0", empty); else pass_cnt++;
      for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 1'b0, exp_d[i]);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total_cnt++;
         if (data_out !== exp_d[i] || dut.count !== exp_c[i])
            $display("FAIL single_read%0d: got %h cnt %0d want %h cnt %0d",
                     i, data_out, dut.count, exp_d[i], exp_c[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (empty !== 1'b1) $display("FAIL single_empty_end: got %b want 1", empty); else pass_cnt++;
      step(1'b0, 1'b0, 1'b0, 8'h00);
      total_cnt++;
      if (data_out !== 8'h00) $display("FAIL single_idle_zero: got %h want 00", data_out); else pass_cnt++;
   endtask

   task automatic test_fill_overflow();
      logic [7:0] saved [DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         saved[i] = 8'($urandom_range(1, 254));
         step(1'b1, 1'b0, 1'b0, saved[i]);
         if (i == DEPTH - 2) begin
            total_cnt++;
            if (full !== 1'b0) $display("FAIL fill_not_full15: got %b want 0", full); else pass_cnt++;
         end
      end
      total_cnt++;
      if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 8'hFF);
      total_cnt++;
      if (full !== 1'b1) $display("FAIL overflow_full: got %b want 1", full); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total_cnt++;
         if (data_out !== saved[i])
            $display("FAIL fill_read%0d: got %h want %h", i, data_out, saved[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (empty !== 1'b1 || full !== 1'b0)
         $display("FAIL fill_drained: got empty=%b full=%b want 1/0", empty, full);
      else pass_cnt++;
   endtask

   task automatic test_full_rw();
      logic [7:0] exp[$];
      logic [7:0] b;
      logic [7:0] want;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         step(1'b1, 1'b0, 1'b0, b);
      end
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
      want = exp.pop_front();
      total_cnt++;
      if (data_out !== want || full !== 1'b0)
         $display("FAIL full_rw: got %h full=%b want %h full=0", data_out, full, want);
      else pass_cnt++;
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         step(1'b1, 1'b1, 1'b0, b);
         want = exp.pop_front();
         total_cnt++;
         if (data_out !== want)
            $display("FAIL stream%0d: got %h want %h", i, data_out, want);
         else pass_cnt++;
      end
      while (exp.size() != 0) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         want = exp.pop_front();
         total_cnt++;
         if (data_out !== want) $display("FAIL stream_drain: got %h want %h", data_out, want);
         else pass_cnt++;
      end
      total_cnt++;
      if (empty !== 1'b1) $display("FAIL stream_empty: got %b want 1", empty); else pass_cnt++;
   endtask

   task automatic test_soft_reset();
      logic [7:0] pk [6] = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h3C};
      logic [6:0] ck [3] = '{7'd5, 7'd4, 7'd3};
      logic [7:0] pk2 [3] = '{8'h05, 8'hB1, 8'h5A};
      step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, pk[i]);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total_cnt++;
         if (data_out !== pk[i] || dut.count !== ck[i])
            $display("FAIL sr_pre%0d: got %h cnt %0d want %h cnt %0d", i, data_out, dut.count, pk[i], ck[i]);
         else pass_cnt++;
      end
      soft_reset = 1'b1;
      step(1'b1, 1'b1, 1'b1, 8'h77);
      soft_reset = 1'b0;
      total_cnt++;
      if (empty !== 1'b1 || data_out !== 8'h00 || dut.count !== 7'd0)
         $display("FAIL soft_reset: got empty=%b dout=%h cnt=%0d want 1/00/0", empty, data_out, dut.count);
      else pass_cnt++;
      total_cnt++;
      if (dut.rd_ptr !== 5'd0 || dut.wr_ptr !== 5'd0)
         $display("FAIL soft_reset_ptr: got rd=%0d wr=%0d want 0/0", dut.rd_ptr, dut.wr_ptr);
      else pass_cnt++;
      step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, pk2[i]);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total_cnt++;
         if (data_out !== pk2[i]) $display("FAIL sr_post%0d: got %h want %h", i, data_out, pk2[i]);
         else pass_cnt++;
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [7] = '{8'h05, 8'hC1, 8'h6E, 8'h09, 8'hD1, 8'hD2, 8'h47};
      logic [6:0] c [7] = '{7'd2, 7'd1, 7'd0, 7'd3, 7'd2, 7'd1, 7'd0};
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, d[0]);
      step(1'b1, 1'b0, 1'b0, d[1]);
      step(1'b1, 1'b0, 1'b1, d[2]);
      for (int i = 3; i < 7; i++) step(1'b1, 1'b0, 1'b0, d[i]);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total_cnt++;
         if (data_out !== d[i] || dut.count !== c[i])
            $display("FAIL b2b_read%0d: got %h cnt %0d want %h cnt %0d", i, data_out, dut.count, d[i], c[i]);
         else pass_cnt++;
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         soft_reset = ($urandom_range(0, 79) == 0);
         step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 7) == 0), 8'($urandom));
         total_cnt++;
         if (data_out !== mdout || empty !== (mq.size() == 0) ||
             full !== (mq.size() == DEPTH) || dut.count !== mcnt)
            $display("FAIL random%0d: got dout=%h e=%b f=%b cnt=%0d want %h %b %b %0d",
                     i, data_out, empty, full, dut.count, mdout,
                     (mq.size() == 0), (mq.size() == DEPTH), mcnt);
         else pass_cnt++;
      end
      soft_reset = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      soft_reset = 1'b0;
      write_enb = 1'b0;
      read_enb = 1'b0;
      lfd_state = 1'b0;
      data_in = 8'h00;
      mdout = 8'h00;
      mcnt = 7'd0;
      mlfd = 1'b0;
      test_reset();
      test_single_packet();
      test_fill_overflow();
      test_full_rw();
      test_soft_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
